// File: rtl/prom_pkg.sv
// Shared types, limits and helpers for the fuse-programmable PROM model.
package prom_pkg;

    localparam int unsigned READ_LAT_MAX = 4;
    localparam int unsigned BURN_CYC_MAX = 255;
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned MERGE_W      = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURN   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } prog_state_e;

    // Legal geometry/timing combination for one PROM site.
    function automatic bit params_ok(input int unsigned addr_w,
                                     input int unsigned data_w,
                                     input int unsigned read_lat,
                                     input int unsigned blank,
                                     input int unsigned burn_cyc);
        return (addr_w >= 1) && (data_w >= 1) && (data_w <= MERGE_W) &&
               (read_lat >= 1) && (read_lat <= READ_LAT_MAX) &&
               (blank <= 1) &&
               (burn_cyc >= 1) && (burn_cyc <= BURN_CYC_MAX);
    endfunction

    // One-way fuse merge: a burned bit never returns to the blank value.
    function automatic logic [MERGE_W-1:0] merge(input logic [MERGE_W-1:0] old,
                                                 input logic [MERGE_W-1:0] data,
                                                 input logic               blank);
        return blank ? (old & data) : (old | data);
    endfunction

endpackage

// File: rtl/prom_rd_pipe.sv
// Valid/data delay line modelling PROM access time; valids clear on reset.
module prom_rd_pipe #(
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0]  vld;
    logic [DATA_W-1:0] dat [DEPTH];

    // Shift one slot per cycle; invalid slots carry zero data so dout idles at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            dat[0] <= in_data;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/prom_fuse_array.sv
// Bipolar PROM model: word array, pipelined read port and fuse-burn port.
module prom_fuse_array
    import prom_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned BLANK    = 0,
    parameter int unsigned BURN_CYC = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce_n,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    input  logic              prog_req,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_busy,
    output logic              prog_done,
    output logic              prog_err
);

    if (!params_ok(ADDR_W, DATA_W, READ_LAT, BLANK, BURN_CYC)) begin : g_param_err
        $error("prom_fuse_array: illegal parameter set");
    end

    localparam int unsigned      DEPTH      = 1 << ADDR_W;
    localparam logic             BLANK_BIT  = (BLANK != 0);
    localparam logic [DATA_W-1:0] BLANK_WORD = {DATA_W{BLANK_BIT}};
    localparam logic [CNT_W-1:0] BURN_LOAD  = CNT_W'(BURN_CYC - 1);

    // Fuse cells hold "blown" flags: an intact cell (0) reads as BLANK.
    logic [DATA_W-1:0] fuse [DEPTH];

    prog_state_e       state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [DATA_W-1:0] data_q, data_nx;
    logic              err_nx, busy_nx, done_nx;
    logic              prog_acc_c, burn_fire_c, rd_acc_c;
    logic [DATA_W-1:0] stored_c, merged_c, rd_word_c;

    assign stored_c = fuse[addr_q] ^ BLANK_WORD;
    assign merged_c = DATA_W'(merge(MERGE_W'(stored_c), MERGE_W'(data_q), BLANK_BIT));

    // Programming state, latched request and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            prog_busy <= 1'b0;
            prog_done <= 1'b0;
            prog_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            addr_q    <= addr_nx;
            data_q    <= data_nx;
            prog_busy <= busy_nx;
            prog_done <= done_nx;
            prog_err  <= err_nx;
        end
    end

    // Burn sequencing: latch, count down the pulse, write, verify, report.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        addr_nx     = addr_q;
        data_nx     = data_q;
        err_nx      = prog_err;
        prog_acc_c  = 1'b0;
        burn_fire_c = 1'b0;
        case (state)
            IDLE: begin
                if (prog_req) begin
                    prog_acc_c = 1'b1;
                    addr_nx    = prog_addr;
                    data_nx    = prog_data;
                    err_nx     = 1'b0;
                    cnt_nx     = BURN_LOAD;
                    state_nx   = BURN;
                end
            end
            BURN: begin
                if (cnt == '0) begin
                    burn_fire_c = 1'b1;
                    state_nx    = VERIFY;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            VERIFY: begin
                if (stored_c != data_q) begin
                    err_nx = 1'b1;
                end
                state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        busy_nx = (state_nx == BURN) || (state_nx == VERIFY);
        done_nx = (state_nx == DONE);
    end

    // Fuse array is non-volatile: no reset, written only on the last burn cycle.
    always_ff @(posedge clk) begin
        if (burn_fire_c) begin
            fuse[addr_q] <= merged_c ^ BLANK_WORD;
        end
    end

    // Read accept: blocked while burning and when a burn request wins the cycle.
    assign rd_acc_c  = !ce_n && !prog_busy && !prog_acc_c;
    assign rd_word_c = rd_acc_c ? (fuse[addr] ^ BLANK_WORD) : '0;

    prom_rd_pipe #(
        .DEPTH  (READ_LAT),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (rd_acc_c),
        .in_data   (rd_word_c),
        .out_valid (rd_valid),
        .out_data  (dout)
    );

endmodule

// File: tb/tb_prom_fuse_array.sv
// Scoreboarded bench for two PROM sites: default geometry and a 3-cycle, blank-high part.
module tb_prom_fuse_array;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    logic       ce_n0, preq0, rdv0, busy0, done0, err0;
    logic [4:0] addr0, paddr0;
    logic [7:0] pdata0, dout0;
    logic       ce_n1, preq1, rdv1, busy1, done1, err1;
    logic [4:0] addr1, paddr1;
    logic [7:0] pdata1, dout1;

    logic [7:0] mdl0 [32];
    logic [7:0] mdl1 [32];
    exp_t       q0 [$];
    exp_t       q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prom_fuse_array #(.ADDR_W(5), .DATA_W(8), .READ_LAT(1), .BLANK(0), .BURN_CYC(16)) u0 (
        .clk(clk), .reset_n(reset_n), .ce_n(ce_n0), .addr(addr0), .dout(dout0),
        .rd_valid(rdv0), .prog_req(preq0), .prog_addr(paddr0), .prog_data(pdata0),
        .prog_busy(busy0), .prog_done(done0), .prog_err(err0));

    prom_fuse_array #(.ADDR_W(5), .DATA_W(8), .READ_LAT(3), .BLANK(1), .BURN_CYC(3)) u1 (
        .clk(clk), .reset_n(reset_n), .ce_n(ce_n1), .addr(addr1), .dout(dout1),
        .rd_valid(rdv1), .prog_req(preq1), .prog_addr(paddr1), .prog_data(pdata1),
        .prog_busy(busy1), .prog_done(done1), .prog_err(err1));

    // Read-port scoreboard for u0: expected word on its due cycle, idle zero otherwise.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (q0.size() != 0 && q0[0].due == cyc) begin
                if (rdv0 !== 1'b1 || dout0 !== q0[0].data) begin
                    errors++;
                    $display("FAIL rd0 cyc=%0d got v=%b d=%h want v=1 d=%h", cyc, rdv0, dout0, q0[0].data);
                end
                q0.delete(0);
            end else if (rdv0 !== 1'b0 || dout0 !== 8'h00) begin
                errors++;
                $display("FAIL rd0_idle cyc=%0d got v=%b d=%h want v=0 d=00", cyc, rdv0, dout0);
            end
        end
    end

    // Read-port scoreboard for u1.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (q1.size() != 0 && q1[0].due == cyc) begin
                if (rdv1 !== 1'b1 || dout1 !== q1[0].data) begin
                    errors++;
                    $display("FAIL rd1 cyc=%0d got v=%b d=%h want v=1 d=%h", cyc, rdv1, dout1, q1[0].data);
                end
                q1.delete(0);
            end else if (rdv1 !== 1'b0 || dout1 !== 8'h00) begin
                errors++;
                $display("FAIL rd1_idle cyc=%0d got v=%b d=%h want v=0 d=00", cyc, rdv1, dout1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ce_n0 = 1'b1; preq0 = 1'b0;
        ce_n1 = 1'b1; preq1 = 1'b0;
        repeat (n) tick();
    endtask

    // Expected read for the upcoming edge; latency 1 on u0, 3 on u1.
    function automatic void push0(input logic [7:0] d);
        q0.push_back('{due: cyc + 1, data: d});
    endfunction

    function automatic void push1(input logic [7:0] d);
        q1.push_back('{due: cyc + 3, data: d});
    endfunction

    function automatic logic [2:0] flags(input int inst);
        return (inst == 0) ? {busy0, done0, err0} : {busy1, done1, err1};
    endfunction

    // Full burn on one instance with cycle-exact busy/done/err expectations.
    task automatic do_burn(input int inst, input logic [4:0] a, input logic [7:0] d);
        int         bc;
        logic [7:0] nw;
        logic       exp_e;
        logic [2:0] f;
        if (inst == 0) begin
            bc = 16; nw = mdl0[a] | d;
            ce_n0 = 1'b1; preq0 = 1'b1; paddr0 = a; pdata0 = d;
        end else begin
            bc = 3; nw = mdl1[a] & d;
            ce_n1 = 1'b1; preq1 = 1'b1; paddr1 = a; pdata1 = d;
        end
        exp_e = (nw != d);
        tick();
        preq0 = 1'b0; preq1 = 1'b0;
        for (int k = 0; k <= bc; k++) begin
            if (k > 0) tick();
            f = flags(inst);
            checks++;
            if (f !== 3'b100) begin
                errors++;
                $display("FAIL burn_busy inst=%0d step=%0d got bde=%b want 100", inst, k, f);
            end
        end
        tick();
        if (inst == 0) mdl0[a] = nw; else mdl1[a] = nw;
        f = flags(inst);
        checks++;
        if (f !== {2'b01, exp_e}) begin
            errors++;
            $display("FAIL burn_done inst=%0d got bde=%b want 01%b", inst, f, exp_e);
        end
        tick();
        f = flags(inst);
        checks++;
        if (f !== {2'b00, exp_e}) begin
            errors++;
            $display("FAIL burn_after inst=%0d got bde=%b want 00%b", inst, f, exp_e);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle(3);
        checks++;
        if ({rdv0, busy0, done0, err0} !== 4'b0000 || dout0 !== 8'h00) begin
            errors++;
            $display("FAIL reset0 got v/b/d/e=%b dout=%h want 0000 00", {rdv0, busy0, done0, err0}, dout0);
        end
        checks++;
        if ({rdv1, busy1, done1, err1} !== 4'b0000 || dout1 !== 8'h00) begin
            errors++;
            $display("FAIL reset1 got v/b/d/e=%b dout=%h want 0000 00", {rdv1, busy1, done1, err1}, dout1);
        end
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_read_all();
        for (int a = 0; a < 32; a++) begin
            ce_n0 = 1'b0; addr0 = 5'(a);
            push0(mdl0[a]);
            tick();
        end
        idle(2);
    endtask

    task automatic test_burn();
        do_burn(0, 5'd3, 8'h5A);
        ce_n0 = 1'b0; addr0 = 5'd3; push0(mdl0[3]); tick();
        idle(2);
    endtask

    task automatic test_overburn();
        do_burn(0, 5'd3, 8'h0F);
        ce_n0 = 1'b0; addr0 = 5'd3; push0(mdl0[3]); tick();
        idle(1);
        do_burn(0, 5'd3, 8'h5F);
        idle(2);
    endtask

    task automatic test_collide();
        ce_n0 = 1'b0; addr0 = 5'd3; push0(mdl0[3]); tick();
        preq0 = 1'b1; paddr0 = 5'd7; pdata0 = 8'h81;
        tick();
        for (int k = 1; k <= 16; k++) begin
            ce_n0 = 1'b0; addr0 = 5'(k);
            preq0 = (k < 8); paddr0 = 5'd8; pdata0 = 8'hFF;
            tick();
            checks++;
            if ({busy0, done0} !== 2'b10) begin
                errors++;
                $display("FAIL collide_busy step=%0d got bd=%b want 10", k, {busy0, done0});
            end
        end
        mdl0[7] = mdl0[7] | 8'h81;
        ce_n0 = 1'b1; preq0 = 1'b0;
        tick();
        checks++;
        if ({busy0, done0, err0} !== 3'b010) begin
            errors++;
            $display("FAIL collide_done got bde=%b want 010", {busy0, done0, err0});
        end
        ce_n0 = 1'b0; addr0 = 5'd7; push0(mdl0[7]);
        preq0 = 1'b1; paddr0 = 5'd8; pdata0 = 8'hFF;
        tick();
        checks++;
        if ({busy0, done0} !== 2'b00) begin
            errors++;
            $display("FAIL collide_ignore got bd=%b want 00", {busy0, done0});
        end
        preq0 = 1'b0; addr0 = 5'd8; push0(mdl0[8]); tick();
        idle(2);
    endtask

    task automatic test_reset_mid();
        do_burn(0, 5'd3, 8'h01);
        reset_n = 1'b0; #1;
        checks++;
        if (err0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 0", err0);
        end
        tick(); reset_n = 1'b1; tick();
        preq0 = 1'b1; paddr0 = 5'd10; pdata0 = 8'hC3;
        tick();
        preq0 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ce_n1 = 1'b0; addr1 = 5'd2; push1(mdl1[2]);
            tick();
        end
        ce_n1 = 1'b1;
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL midburn_busy got %b want 1", busy0);
        end
        reset_n = 1'b0; #1;
        q0.delete(); q1.delete();
        checks++;
        if ({rdv0, busy0, done0, err0, rdv1} !== 5'b0 || dout0 !== 8'h00 || dout1 !== 8'h00) begin
            errors++;
            $display("FAIL midburn_reset got v/b/d/e/v1=%b d0=%h d1=%h want 00000 00 00",
                     {rdv0, busy0, done0, err0, rdv1}, dout0, dout1);
        end
        tick(); reset_n = 1'b1; tick();
        ce_n0 = 1'b0; addr0 = 5'd10; push0(mdl0[10]); tick();
        idle(2);
    endtask

    task automatic test_lat3();
        logic [4:0] pat;
        pat = 5'b01001;
        for (int i = 0; i < 5; i++) begin
            ce_n1 = pat[i]; addr1 = 5'(i);
            if (!pat[i]) push1(mdl1[i]);
            tick();
        end
        idle(4);
    endtask

    task automatic test_blank1();
        do_burn(1, 5'd0, 8'hA5);
        ce_n1 = 1'b0;
        addr1 = 5'd0;  push1(mdl1[0]);  tick();
        addr1 = 5'd1;  push1(mdl1[1]);  tick();
        addr1 = 5'd31; push1(mdl1[31]); tick();
        idle(4);
        do_burn(1, 5'd0, 8'h0F);
        ce_n1 = 1'b0; addr1 = 5'd0; push1(mdl1[0]); tick();
        idle(4);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mdl0[i] = 8'h00;
            mdl1[i] = 8'hFF;
        end
        ce_n0 = 1'b1; addr0 = '0; preq0 = 1'b0; paddr0 = '0; pdata0 = '0;
        ce_n1 = 1'b1; addr1 = '0; preq1 = 1'b0; paddr1 = '0; pdata1 = '0;

        test_reset();
        test_read_all();
        test_burn();
        test_overburn();
        test_collide();
        test_reset_mid();
        test_lat3();
        test_blank1();

        idle(5);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain got q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
